// File: rtl/instr_sequencer.sv
// Program sequencer: walks a synchronous instruction memory and issues one instruction
// at a time to the instruction unit. Define INSTR_SEQ_WDOG_EN to enable the done watchdog.
module instr_sequencer #(
  parameter int unsigned IMEM_DEPTH  = 1000,
  parameter int unsigned AW          = 10,
  parameter int unsigned CW          = 16,
  parameter int unsigned WDOG_CYCLES = 255,
  localparam int unsigned IW         = 19
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          go,
  input  logic          abort,
  input  logic [AW-1:0] prog_len,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          done,
  output logic          busy,
  output logic          finished,
  output logic [AW-1:0] pc,
  output logic [CW-1:0] instr_count,
  output logic          timeout
);

  localparam int unsigned LW = AW + 1;

  if ((64'(1) << AW) < 64'(IMEM_DEPTH)) begin : g_aw_chk
    $error("instr_sequencer: AW too small for IMEM_DEPTH");
  end
  if (WDOG_CYCLES == 0) begin : g_wdog_chk
    $error("instr_sequencer: WDOG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

  state_t        state;
  logic [LW-1:0] len;
  logic [LW-1:0] len_clamp_c;
  logic          last_c;
  logic          retire_c;

  assign busy        = (state != IDLE);
  assign last_c      = (LW'(pc) == len - LW'(1));
  // Programs longer than the memory are truncated so pc stays in range
  assign len_clamp_c = (LW'(prog_len) > LW'(IMEM_DEPTH)) ? LW'(IMEM_DEPTH) : LW'(prog_len);

`ifdef INSTR_SEQ_WDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] wdog_cnt;
  logic           expire_c;

  assign expire_c = !done && (wdog_cnt == WDW'(WDOG_CYCLES - 1));
  assign retire_c = done || expire_c;

  // Watchdog counts WAIT cycles without done; the timeout flag is sticky until the next run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
    end else if (!abort) begin
      if (state == IDLE) begin
        if (go && (prog_len != '0)) timeout <= 1'b0;
      end else if (state == ISSUE) begin
        wdog_cnt <= '0;
      end else if ((state == WAIT) && !done) begin
        wdog_cnt <= wdog_cnt + WDW'(1);
        if (expire_c) timeout <= 1'b1;
      end
    end
  end
`else
  assign retire_c = done;
  assign timeout  = 1'b0;
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      len         <= '0;
      pc          <= '0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      finished    <= 1'b0;
      instr_count <= '0;
    end else begin
      instr_valid <= 1'b0;
      finished    <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              if (prog_len == '0) begin
                finished <= 1'b1;
              end else begin
                len         <= len_clamp_c;
                pc          <= '0;
                imem_addr   <= '0;
                instr_count <= '0;
                state       <= FETCH;
              end
            end
          end
          FETCH: state <= ISSUE;
          ISSUE: begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            state       <= WAIT;
          end
          WAIT: begin
            if (retire_c) begin
              instr_count <= instr_count + CW'(1);
              if (last_c) begin
                finished <= 1'b1;
                state    <= IDLE;
              end else begin
                pc        <= pc + AW'(1);
                imem_addr <= pc + AW'(1);
                state     <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand-written reset/abort
// sequences and randomized runs checked against a cycle-level program model.
module tb_instr_sequencer;

  localparam int unsigned AW    = 10;
  localparam int unsigned CW    = 16;
  localparam int unsigned IW    = 19;
  localparam int          DEPTH = 1000;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          go       = 1'b0;
  logic          abort    = 1'b0;
  logic          done     = 1'b0;
  logic [AW-1:0] prog_len = '0;
  logic [AW-1:0] imem_addr;
  logic [AW-1:0] pc;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [CW-1:0] instr_count;

  logic [IW-1:0] imem [0:1023];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int plen;
    int lat;       // >=0: done pulse lat cycles after issue; -1: done held high; -2: random done
    int abort_at;  // pc at which to abort (with done) in the issue cycle, -1 for none
    int exp_cnt;
    int exp_pc;
    int exp_fin;
  } vec_t;

  vec_t vecs [8];

  instr_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .go          (go),
    .abort       (abort),
    .prog_len    (prog_len),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .done        (done),
    .busy        (busy),
    .finished    (finished),
    .pc          (pc),
    .instr_count (instr_count),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid one cycle after the address
  always_ff @(posedge clk) imem_data <= imem[imem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " imem_addr"},   64'(imem_addr),   0);
    check({tag, " instr"},       64'(instr),       0);
    check({tag, " instr_valid"}, 64'(instr_valid), 0);
    check({tag, " busy"},        64'(busy),        0);
    check({tag, " finished"},    64'(finished),    0);
    check({tag, " pc"},          64'(pc),          0);
    check({tag, " instr_count"}, 64'(instr_count), 0);
    check({tag, " timeout"},     64'(timeout),     0);
  endtask

  // Model: instruction i issues 3 cycles after instruction i-1 retires (first one 3 cycles
  // after go), retires at the first done seen from its issue cycle on, finish follows the last.
  task automatic run_prog(input string tag, input int plen, input int lat, input int abort_at,
                          output int fin_seen);
    int len, idx, retired, fin_cyc, exp_valid_cyc, wcnt, budget;
    int bad_valid, bad_instr, bad_cnt, bad_busy, bad_fin;
    bit in_wait, aborted;
    len       = (plen > DEPTH) ? DEPTH : plen;
    idx       = 0;
    retired   = 0;
    wcnt      = 0;
    bad_valid = 0;
    bad_instr = 0;
    bad_cnt   = 0;
    bad_busy  = 0;
    bad_fin   = 0;
    in_wait   = 1'b0;
    aborted   = 1'b0;
    fin_seen  = 0;
    fin_cyc   = (len == 0) ? 0 : -1;
    exp_valid_cyc = 2;
    budget    = 20 * len + 40;

    done     = (lat == -1);
    go       = 1'b1;
    prog_len = AW'(plen);
    step();
    go = 1'b0;

    for (int cyc = 0; cyc < budget; cyc++) begin
      bit exp_v;
      exp_v = !in_wait && (idx < len) && (cyc == exp_valid_cyc);
      if (instr_valid !== exp_v) bad_valid++;
      if (finished === 1'b1) fin_seen++;
      if (finished !== (cyc == fin_cyc)) bad_fin++;
      if (busy !== (cyc != fin_cyc)) bad_busy++;
      if (instr_count !== CW'(retired)) bad_cnt++;
      if (exp_v) begin
        in_wait = 1'b1;
        wcnt    = lat;
        idx++;
      end
      if (in_wait) begin
        if (instr !== imem[idx-1] || pc !== AW'(idx-1) || imem_addr !== AW'(idx-1)) bad_instr++;
      end
      if (cyc == fin_cyc) break;
      if (exp_v && (idx - 1 == abort_at)) begin
        abort = 1'b1;
        done  = 1'b1;
        step();
        abort   = 1'b0;
        done    = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (lat == -1)      done = 1'b1;
      else if (lat == -2) done = ($urandom_range(0, 99) < 40);
      else                done = in_wait && (wcnt == 0);
      if (in_wait && wcnt > 0) wcnt--;
      if (in_wait && done) begin
        in_wait = 1'b0;
        retired++;
        if (retired == len) fin_cyc = cyc + 1;
        else                exp_valid_cyc = cyc + 3;
      end
      step();
    end

    done = 1'b0;
    if (!aborted) step();
    for (int k = 0; k < 3; k++) begin
      if (busy !== 1'b0) bad_busy++;
      if (finished !== 1'b0) begin
        bad_fin++;
        fin_seen++;
      end
      if (instr_valid !== 1'b0) bad_valid++;
      step();
    end

    check({tag, " issue_timing"}, 64'(bad_valid), 0);
    check({tag, " instr_pc"},     64'(bad_instr), 0);
    check({tag, " count_track"},  64'(bad_cnt),   0);
    check({tag, " busy_track"},   64'(bad_busy),  0);
    check({tag, " finish_pulse"}, 64'(bad_fin),   0);
    check({tag, " timeout"},      64'(timeout),   0);
  endtask

  task automatic do_vec(input string tag, input vec_t v);
    int fin_seen;
    run_prog(tag, v.plen, v.lat, v.abort_at, fin_seen);
    check({tag, " instr_count"}, 64'(instr_count), 64'(v.exp_cnt));
    check({tag, " pc"},          64'(pc),          64'(v.exp_pc));
    check({tag, " finished_n"},  64'(fin_seen),    64'(v.exp_fin));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = IW'($urandom);

    vecs[0] = '{0,    0,  -1, 0,    0,   1};
    vecs[1] = '{4,    1,  -1, 4,    3,   1};
    vecs[2] = '{4,    0,  -1, 4,    3,   1};
    vecs[3] = '{6,    -1, -1, 6,    5,   1};
    vecs[4] = '{4,    0,  2,  2,    2,   0};
    vecs[5] = '{1,    3,  -1, 1,    0,   1};
    vecs[6] = '{7,    -2, -1, 7,    6,   1};
    vecs[7] = '{1023, 0,  -1, 1000, 999, 1};

    reset_n = 1'b0;
    step();
    step();
    check_reset_vals("por");
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) do_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted in the middle of a WAIT
    go       = 1'b1;
    prog_len = AW'(4);
    step();
    go = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (instr_valid === 1'b1 && pc === AW'(1)) break;
      done = instr_valid;
      step();
    end
    done = 1'b0;
    check("rst_mid reach",       64'(instr_valid), 1);
    check("rst_mid instr_count", 64'(instr_count), 1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    step();
    reset_n = 1'b1;
    step();
    do_vec("post_rst", '{4, 1, -1, 4, 3, 1});

    // Randomized programs, done behaviour and occasional aborts
    for (int r = 0; r < 10; r++) begin
      vec_t v;
      v.plen     = int'($urandom_range(1, 12));
      v.lat      = int'($urandom_range(0, 5)) - 2;
      v.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, v.plen - 1)) : -1;
      v.exp_cnt  = (v.abort_at >= 0) ? v.abort_at : v.plen;
      v.exp_pc   = (v.abort_at >= 0) ? v.abort_at : v.plen - 1;
      v.exp_fin  = (v.abort_at >= 0) ? 0 : 1;
      for (int i = 0; i < 16; i++) imem[i] = IW'($urandom);
      do_vec($sformatf("rnd%0d", r), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
